// File: rtl/tdc_pulse_gen.sv
// Start/stop pulse-pair generator for TDC calibration. It returns the TDC count as a result.
// Build with TDC_PG_ACCUM_EN defined to add a saturating result accumulator (o_acc, cleared by i_acc_clr).
module tdc_pulse_gen #(
  parameter int DW        = 16,
  parameter int STOP_HOLD = 2,
  parameter int ACC_W     = 40
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_go,
  input  logic          i_abort,
  input  logic [DW-1:0] i_delay_cycles,
  input  logic [31:0]   i_meas_in,
`ifdef TDC_PG_ACCUM_EN
  input  logic             i_acc_clr,
  output logic [ACC_W-1:0] o_acc,
`endif
  output logic          o_start,
  output logic          o_stop,
  output logic          o_busy,
  output logic [31:0]   o_result,
  output logic          o_result_valid,
  output logic [15:0]   o_meas_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DELAY, S_STOP, S_SETTLE, S_DONE
  } state_t;

  state_t        r_state, w_next;
  logic [DW-1:0] r_dly, r_cnt;
  logic          r_start, r_stop, r_busy, r_rv;
  logic [31:0]   r_result;
  logic [15:0]   r_meas_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst_n) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (i_go) w_next = S_START;
      S_START:  w_next = S_DELAY;
      S_DELAY:  if (r_cnt <= DW'(1)) w_next = S_STOP;
      S_STOP:   if (r_cnt <= DW'(1)) w_next = S_SETTLE;
      S_SETTLE: w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (i_abort && r_state != S_IDLE) w_next = S_IDLE;
  end

  // Outputs are registered from the next state, so each one lines up with the state it describes.
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
      r_busy     <= 1'b0;
      r_rv       <= 1'b0;
      r_dly      <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_meas_cnt <= '0;
    end else begin
      r_start <= (w_next == S_START);
      r_stop  <= (w_next == S_STOP);
      r_busy  <= (w_next != S_IDLE);
      r_rv    <= (w_next == S_DONE);
      if (r_state == S_IDLE && i_go)
        r_dly <= (i_delay_cycles == '0) ? DW'(1) : i_delay_cycles;
      // A single down-counter times both the DELAY phase and the STOP hold.
      if (w_next == S_IDLE)
        r_cnt <= '0;
      else if (r_state == S_START)
        r_cnt <= r_dly;
      else if (r_state == S_DELAY && w_next == S_STOP)
        r_cnt <= DW'(STOP_HOLD);
      else if (r_state == S_DELAY || r_state == S_STOP)
        r_cnt <= r_cnt - DW'(1);
      if (r_state == S_SETTLE && w_next == S_DONE) begin
        r_result   <= i_meas_in;
        r_meas_cnt <= r_meas_cnt + 16'd1;
      end
    end
  end

`ifdef TDC_PG_ACCUM_EN
  localparam int SW = ((ACC_W > 32) ? ACC_W : 32) + 1;
  logic [ACC_W-1:0] r_acc;
  logic [SW-1:0]    w_base, w_sum;

  // A clear that coincides with DONE restarts the sum from the new result.
  always_comb begin
    w_base = i_acc_clr ? '0 : SW'(r_acc);
    w_sum  = w_base + SW'(r_result);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n)
      r_acc <= '0;
    else if (r_state == S_DONE)
      r_acc <= (w_sum > SW'({ACC_W{1'b1}})) ? {ACC_W{1'b1}} : ACC_W'(w_sum);
    else if (i_acc_clr)
      r_acc <= '0;
  end

  assign o_acc = r_acc;
`endif

  assign o_start        = r_start;
  assign o_stop         = r_stop;
  assign o_busy         = r_busy;
  assign o_result       = r_result;
  assign o_result_valid = r_rv;
  assign o_meas_cnt     = r_meas_cnt;

endmodule

// File: doc/tdc_pulse_gen.md
# tdc_pulse_gen

Stimulus-side partner of the TDC delay measurement block. It generates the `start`/`stop` pulse pair with a programmed clock-cycle separation, waits for the TDC to latch its count, and captures the returned `time_count` as a result. It sits between the tile's control/test logic and the TDC inputs and closes the loop for on-chip calibration of the ring-oscillator delay line.

## Interface
- `DW`, 16: width of the delay setting and of the internal delay counter.
- `STOP_HOLD`, 2: number of cycles `stop` is held high; legal values are ≥2, because the TDC needs one cycle to clear `counting` and one cycle to capture.
- `ACC_W`, 40: accumulator width; used only when `TDC_PG_ACCUM_EN` is defined.

- `clk`  in  1  single system clock; all logic is clocked on its rising edge.
- `rst_n`  in  1  synchronous, **active-high** reset; the port name is kept for codebase consistency.
- `go`  in  1  request to run one measurement; sampled only in IDLE.
- `abort`  in  1  synchronous cancel of a measurement in progress.
- `delay_cycles`  in  DW  start-to-stop spacing setting; latched when `go` is accepted.
- `meas_in`  in  32  `time_count` returned from the TDC.
- `start`  out  1  one-cycle start pulse to the TDC.
- `stop`  out  1  stop level to the TDC, high for STOP_HOLD cycles.
- `busy`  out  1  high in every state except IDLE.
- `result`  out  32  last captured `meas_in`.
- `result_valid`  out  1  one-cycle strobe that accompanies a new `result`.
- `meas_cnt`  out  16  count of completed measurements; wraps modulo 2^16.

## Operation
- FSM states: IDLE → START → DELAY → STOP → SETTLE → DONE → IDLE.
- IDLE: when `go`=1, latch `dly = max(delay_cycles, 1)` and go to START. `go` is ignored in every other state.
- START: `start`=1 for exactly one cycle. Load the counter with `dly`, then go to DELAY.
- DELAY: decrement the counter each cycle. Go to STOP in the cycle the counter reaches 1, so DELAY lasts exactly `dly` cycles.
- STOP: `stop`=1 for STOP_HOLD cycles, then go to SETTLE.
- SETTLE: hold for one cycle with `start`=`stop`=0. At the end of the cycle, register `result <= meas_in`.
- DONE: one cycle with `result_valid`=1 and `meas_cnt` incremented.
- `abort`=1 in any non-IDLE state moves the FSM to IDLE on the next edge:
  - `start` and `stop` go low.
  - No `result_valid` is issued.
  - `result` and `meas_cnt` are unchanged.
  - `abort` takes precedence over every other transition. `abort` in IDLE has no effect.
- A `go` that arrives in the DONE cycle is dropped. A new `go` is accepted only in IDLE, so back-to-back runs are separated by at least one IDLE cycle.
- `delay_cycles`=0 behaves identically to `delay_cycles`=1.

## Timing
- Take edge E0 as the edge that accepts `go`.
- `start` is high in cycle 1, the cycle after E0.
- `stop` rises in cycle `dly`+2, so start-rise to stop-rise is `dly`+1 cycles.
- `stop` falls after cycle `dly`+1+STOP_HOLD.
- `result` updates and `result_valid` is high in cycle `dly`+3+STOP_HOLD.
- Total busy time is `dly`+3+STOP_HOLD cycles.
- Reset values: state IDLE, `start`=0, `stop`=0, `busy`=0, `result`=0, `result_valid`=0, `meas_cnt`=0, counter=0.
- Reset asserted mid-measurement forces IDLE and all reset values on the next edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `TDC_PG_ACCUM_EN` defined:
  - Adds input `acc_clr` (1 bit) and output `acc` (ACC_W bits). Both reset to 0.
  - Each DONE cycle sets `acc <= acc + result`, saturating at all-ones.
  - `acc_clr`=1 sets `acc` to 0. If `acc_clr` and DONE coincide, `acc` is set to the new `result`.
- `TDC_PG_ACCUM_EN` not defined: the `acc`/`acc_clr` ports and the accumulator logic are absent. All other behaviour is identical.

## Test plan
- Reset, then `go` with `delay_cycles`=5 and `meas_in`=0x1234: `start` is high in cycle 1, `stop` is high in cycles 7–8, `result`=0x1234 with `result_valid` in cycle 10, and `meas_cnt`=1.
- `delay_cycles`=0: the timing matches `delay_cycles`=1, with `stop` rising 2 cycles after `start`.
- `go` pulsed during DELAY, and again in the DONE cycle: both are ignored, and exactly one `result_valid` is produced.
- `abort` in the second cycle of STOP: IDLE on the next edge, `stop`=0, no `result_valid`, and `result`/`meas_cnt` hold their prior values. A following `go` runs normally.
- `rst_n` asserted during DELAY with `meas_cnt`=3: all outputs go to their reset values on the next edge, including `meas_cnt`=0.
- With `TDC_PG_ACCUM_EN`, ACC_W=8, and `meas_in`=200 over two runs: `acc`=200, then 255 (saturated). Then `acc_clr`=1 gives `acc`=0.
